// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the physical register file write port between WB_NUM
// execute units, plus the per-physical-register "value written" scoreboard.
module wb_port_arbiter #(
  parameter  int WB_NUM  = 4,
  parameter  int DW      = 64,
  parameter  int RNBIT   = 2,
  parameter  int RNDEPTH = 4,
  localparam int IW      = 5 + RNBIT,
  localparam int NP      = 32 * RNDEPTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WB_NUM-1:0]    wb_req_vaild,
  output logic [WB_NUM-1:0]    wb_req_ready,
  input  logic [WB_NUM*IW-1:0] wb_req_index,
  input  logic [WB_NUM*DW-1:0] wb_req_data,
  output logic                 regFileX_wr_en,
  output logic [IW-1:0]        regFileX_wr_index,
  output logic [DW-1:0]        regFileX_wr_data,
  input  logic                 rn_alloc_vaild,
  input  logic [IW-1:0]        rn_alloc_index,
  output logic [NP-1:0]        writeBackBuffer_qout
);

  localparam int PW = (WB_NUM > 1) ? $clog2(WB_NUM) : 1;

  // Copy 0 of every architectural register starts out holding its value.
  function automatic logic [NP-1:0] sb_reset_value();
    logic [NP-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p += RNDEPTH) v[p] = 1'b1;
    return v;
  endfunction

  localparam logic [NP-1:0] SB_INIT = sb_reset_value();

  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  grant_idx;
  logic [PW-1:0]  next_ptr;
  logic           grant_valid;
  logic [IW-1:0]  sel_index;
  logic [DW-1:0]  sel_data;
  logic           do_write;
  logic [NP-1:0]  sb_next;
  logic [PW:0]    cand_sum;
  logic [PW-1:0]  cand;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    sel_index    = '0;
    sel_data     = '0;
    cand_sum     = '0;
    cand         = '0;
    wb_req_ready = '0;
    for (int k = 0; k < WB_NUM; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand_sum >= (PW+1)'(WB_NUM)) cand_sum = cand_sum - (PW+1)'(WB_NUM);
      cand = cand_sum[PW-1:0];
      if (!grant_valid && wb_req_vaild[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    for (int k = 0; k < WB_NUM; k++) begin
      if (grant_valid && grant_idx == PW'(k)) begin
        sel_index = wb_req_index[k*IW +: IW];
        sel_data  = wb_req_data[k*DW +: DW];
        if (!RST) wb_req_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr = '0;
    if (grant_idx != PW'(WB_NUM-1)) next_ptr = grant_idx + PW'(1);
  end

  // Writes to x0 are consumed but never reach the register file or the scoreboard.
  assign do_write = grant_valid && (sel_index[IW-1:RNBIT] != '0);

  // Clear first, then set, so a same-index set wins.
  always_comb begin
    sb_next = writeBackBuffer_qout;
    if (rn_alloc_vaild && rn_alloc_index[IW-1:RNBIT] != '0)
      sb_next[rn_alloc_index] = 1'b0;
    if (do_write)
      sb_next[sel_index] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr               <= '0;
      regFileX_wr_en       <= 1'b0;
      regFileX_wr_index    <= '0;
      regFileX_wr_data     <= '0;
      writeBackBuffer_qout <= SB_INIT;
    end else begin
      if (grant_valid) rr_ptr <= next_ptr;
      regFileX_wr_en <= do_write;
      if (do_write) begin
        regFileX_wr_index <= sel_index;
        regFileX_wr_data  <= sel_data;
      end
      writeBackBuffer_qout <= sb_next;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, round-robin order, single requester,
// scoreboard set/clear interaction, x0 writes and mid-stream reset.
module tb_wb_port_arbiter;

  localparam int WB_NUM  = 4;
  localparam int DW      = 64;
  localparam int RNBIT   = 2;
  localparam int RNDEPTH = 4;
  localparam int IW      = 5 + RNBIT;
  localparam int NP      = 32 * RNDEPTH;
  localparam logic [NP-1:0] SB_INIT = {32{4'b0001}};

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [WB_NUM-1:0]    wb_req_vaild;
  logic [WB_NUM-1:0]    wb_req_ready;
  logic [WB_NUM*IW-1:0] wb_req_index;
  logic [WB_NUM*DW-1:0] wb_req_data;
  logic                 regFileX_wr_en;
  logic [IW-1:0]        regFileX_wr_index;
  logic [DW-1:0]        regFileX_wr_data;
  logic                 rn_alloc_vaild;
  logic [IW-1:0]        rn_alloc_index;
  logic [NP-1:0]        writeBackBuffer_qout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NP-1:0] exp_sb;
  logic [IW-1:0] exp_idx;

  wb_port_arbiter #(.WB_NUM(WB_NUM), .DW(DW), .RNBIT(RNBIT), .RNDEPTH(RNDEPTH)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .wb_req_vaild         (wb_req_vaild),
    .wb_req_ready         (wb_req_ready),
    .wb_req_index         (wb_req_index),
    .wb_req_data          (wb_req_data),
    .regFileX_wr_en       (regFileX_wr_en),
    .regFileX_wr_index    (regFileX_wr_index),
    .regFileX_wr_data     (regFileX_wr_data),
    .rn_alloc_vaild       (rn_alloc_vaild),
    .rn_alloc_index       (rn_alloc_index),
    .writeBackBuffer_qout (writeBackBuffer_qout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [IW-1:0] idx, input logic [DW-1:0] data);
    wb_req_index[i*IW +: IW] = idx;
    wb_req_data[i*DW +: DW]  = data;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [IW-1:0] rr_index(input int g);
    return IW'((8 + g) * RNDEPTH + 1);
  endfunction

  initial begin
    RST = 1'b1;
    wb_req_vaild   = '0;
    wb_req_index   = '0;
    wb_req_data    = '0;
    rn_alloc_vaild = 1'b0;
    rn_alloc_index = '0;

    // Reset values
    #2;
    check("rst_wr_en",    regFileX_wr_en, '0);
    check("rst_wr_index", regFileX_wr_index, '0);
    check("rst_wr_data",  regFileX_wr_data, '0);
    check("rst_qout",     writeBackBuffer_qout, SB_INIT);
    wb_req_vaild = 4'hf;
    #1;
    check("rst_ready_gated", wb_req_ready, '0);
    wb_req_vaild = '0;
    step();
    step();
    RST = 1'b0;
    step();
    step();
    check("idle_wr_en", regFileX_wr_en, '0);
    check("idle_qout",  writeBackBuffer_qout, SB_INIT);

    // All four requesters valid: strict rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < WB_NUM; i++) set_req(i, rr_index(i), DW'(64'h1000 + i));
    wb_req_vaild = 4'hf;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr_ready_c%0d", c), wb_req_ready, NP'(4'b0001 << (c % 4)));
      step();
      check($sformatf("rr_wr_en_c%0d", c),  regFileX_wr_en, '1 >> (NP-1));
      check($sformatf("rr_index_c%0d", c),  regFileX_wr_index, rr_index(c % 4));
      check($sformatf("rr_data_c%0d", c),   regFileX_wr_data, DW'(64'h1000 + (c % 4)));
    end
    exp_sb = SB_INIT;
    for (int i = 0; i < WB_NUM; i++) exp_sb[rr_index(i)] = 1'b1;
    check("rr_qout", writeBackBuffer_qout, exp_sb);
    wb_req_vaild = '0;
    step();
    check("rr_drain_wr_en", regFileX_wr_en, '0);

    // Single requester 2, back-to-back writes
    set_req(2, 7'd21, 64'hDEAD);
    wb_req_vaild = 4'b0100;
    #1;
    check("solo_ready_a", wb_req_ready, NP'(4'b0100));
    step();
    exp_sb[21] = 1'b1;
    check("solo_wr_en_a",  regFileX_wr_en, NP'(1));
    check("solo_index_a",  regFileX_wr_index, NP'(21));
    check("solo_data_a",   regFileX_wr_data, NP'(64'hDEAD));
    check("solo_qout_a",   writeBackBuffer_qout, exp_sb);
    set_req(2, 7'd22, 64'hBEEF);
    #1;
    check("solo_ready_b", wb_req_ready, NP'(4'b0100));
    step();
    exp_sb[22] = 1'b1;
    check("solo_wr_en_b", regFileX_wr_en, NP'(1));
    check("solo_index_b", regFileX_wr_index, NP'(22));
    check("solo_data_b",  regFileX_wr_data, NP'(64'hBEEF));
    check("solo_qout_b",  writeBackBuffer_qout, exp_sb);
    wb_req_vaild = '0;

    // Allocation clears; same-index set wins; different indices both apply
    rn_alloc_vaild = 1'b1;
    rn_alloc_index = 7'd21;
    step();
    exp_sb[21] = 1'b0;
    check("alloc_clear_qout", writeBackBuffer_qout, exp_sb);
    check("alloc_clear_wr_en", regFileX_wr_en, '0);
    set_req(2, 7'd21, 64'h55);
    wb_req_vaild = 4'b0100;
    step();
    exp_sb[21] = 1'b1;
    check("alloc_set_wins_qout", writeBackBuffer_qout, exp_sb);
    check("alloc_set_wins_data", regFileX_wr_data, NP'(64'h55));
    rn_alloc_index = rr_index(0);
    set_req(2, 7'd22, 64'h66);
    step();
    exp_sb[rr_index(0)] = 1'b0;
    exp_sb[22] = 1'b1;
    check("alloc_both_apply_qout", writeBackBuffer_qout, exp_sb);
    wb_req_vaild   = '0;
    rn_alloc_index = 7'd0;
    step();
    check("alloc_x0_ignored_qout", writeBackBuffer_qout, exp_sb);
    rn_alloc_vaild = 1'b0;

    // Write to arch 0 from requester 1 (pointer sits at 3 -> searches 3,0,1)
    set_req(1, 7'd2, 64'h77);
    wb_req_vaild = 4'b0010;
    #1;
    check("x0_ready", wb_req_ready, NP'(4'b0010));
    step();
    check("x0_wr_en", regFileX_wr_en, '0);
    check("x0_qout",  writeBackBuffer_qout, exp_sb);

    // Mid-stream reset with requesters 1..3 valid (pointer at 2)
    set_req(1, 7'd41, 64'hA1);
    set_req(2, 7'd42, 64'hA2);
    set_req(3, 7'd43, 64'hA3);
    wb_req_vaild = 4'b1110;
    #1;
    check("mid_ready_pre", wb_req_ready, NP'(4'b0100));
    step();
    check("mid_wr_en_pre", regFileX_wr_en, NP'(1));
    check("mid_index_pre", regFileX_wr_index, NP'(42));
    RST = 1'b1;
    #1;
    check("mid_rst_wr_en", regFileX_wr_en, '0);
    check("mid_rst_index", regFileX_wr_index, '0);
    check("mid_rst_qout",  writeBackBuffer_qout, SB_INIT);
    check("mid_rst_ready", wb_req_ready, '0);
    step();
    RST = 1'b0;
    #1;
    check("post_rst_ready_1", wb_req_ready, NP'(4'b0010));
    step();
    exp_idx = 7'd41;
    exp_sb  = SB_INIT;
    exp_sb[exp_idx] = 1'b1;
    check("post_rst_wr_en", regFileX_wr_en, NP'(1));
    check("post_rst_index", regFileX_wr_index, NP'(exp_idx));
    check("post_rst_data",  regFileX_wr_data, NP'(64'hA1));
    check("post_rst_qout",  writeBackBuffer_qout, exp_sb);
    #1;
    check("post_rst_ready_2", wb_req_ready, NP'(4'b0100));
    step();
    check("post_rst_index_2", regFileX_wr_index, NP'(42));
    #1;
    check("post_rst_ready_3", wb_req_ready, NP'(4'b1000));
    step();
    check("post_rst_index_3", regFileX_wr_index, NP'(43));
    wb_req_vaild = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
